// File: rtl/demux1_l1_pkg.sv
// Shared phy lane definitions used by the tx interleaver and the rx demux.
package demux1_l1_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LANES      = 2;
  localparam int unsigned LANE_W     = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LANE0 = lane_t'(0);
  localparam lane_t LANE1 = lane_t'(1);

endpackage

// File: rtl/demux1_l1_if.sv
// Serial input and recovered lane-pair bus of the rx lane demux.
interface demux1_l1_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ERR_W  = 8
);

  logic [DATA_W-1:0] data_00;
  logic              valid_00;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              valid_0;
  logic              valid_1;
  logic              pair_stb;
  logic [ERR_W-1:0]  err_cnt;

  // Upstream side: drives the interleaved stream, observes the pair.
  modport master (
    output data_00, valid_00,
    input  data_0, data_1, valid_0, valid_1, pair_stb, err_cnt
  );

  // Demux side: consumes the stream, produces the aligned pair.
  modport slave (
    input  data_00, valid_00,
    output data_0, data_1, valid_0, valid_1, pair_stb, err_cnt
  );

endinterface

// File: rtl/demux1_l1_sat_counter.sv
// Saturating up-counter for rx error statistics.
module demux1_l1_sat_counter #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [ERR_W-1:0] o_count
);

  logic [ERR_W-1:0] r_count;

  // Increment on request, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ERR_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/demux1_l1.sv
// Rx 1:2 lane demux: splits the clk_2f interleaved stream into an aligned lane pair.
module demux1_l1
  import demux1_l1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ERR_W  = 8
) (
  input  logic       clk_2f,
  input  logic       reset,
  demux1_l1_if.slave bus
);

  lane_t             r_sel;
  lane_t             w_sel_nxt;
  logic              w_slot1;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_data_0;
  logic [DATA_W-1:0] r_data_1;
  logic              r_valid_0;
  logic              r_valid_1;
  logic              r_pair_stb;
  logic              w_err_inc;
  logic [ERR_W-1:0]  w_err_cnt;

  // Next slot: alternate lanes every edge regardless of valid.
  always_comb begin
    w_sel_nxt = LANE0;
    if (r_sel == LANE0) begin
      w_sel_nxt = LANE1;
    end
  end

  assign w_slot1   = (r_sel == LANE1);
  assign w_err_inc = w_slot1 && (r_hold_valid ^ bus.valid_00);

  // Free-running slot selector; first edge after reset is lane 0.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_sel <= LANE0;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  // Capture the lane 0 word until its lane 1 partner arrives.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (!w_slot1) begin
      r_hold_valid <= bus.valid_00;
      if (bus.valid_00) begin
        r_hold_data <= bus.data_00;
      end
    end
  end

  // Publish the pair on lane 1 edges; invalid words never overwrite data.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_data_0   <= '0;
      r_data_1   <= '0;
      r_valid_0  <= 1'b0;
      r_valid_1  <= 1'b0;
      r_pair_stb <= 1'b0;
    end else if (w_slot1) begin
      r_valid_0  <= r_hold_valid;
      r_valid_1  <= bus.valid_00;
      r_pair_stb <= 1'b1;
      if (r_hold_valid) begin
        r_data_0 <= r_hold_data;
      end
      if (bus.valid_00) begin
        r_data_1 <= bus.data_00;
      end
    end else begin
      r_pair_stb <= 1'b0;
    end
  end

  // Count pairs where exactly one lane was valid.
  demux1_l1_sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk     (clk_2f),
    .rst     (reset),
    .i_inc   (w_err_inc),
    .o_count (w_err_cnt)
  );

  assign bus.data_0   = r_data_0;
  assign bus.data_1   = r_data_1;
  assign bus.valid_0  = r_valid_0;
  assign bus.valid_1  = r_valid_1;
  assign bus.pair_stb = r_pair_stb;
  assign bus.err_cnt  = w_err_cnt;

endmodule

// File: tb/tb_demux1_l1.sv
// Bench for the rx lane demux: directed scenarios plus a randomized tx loopback.
module tb_demux1_l1;

  localparam int unsigned DW = 8;
  localparam int unsigned EW = 8;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  demux1_l1_if #(.DATA_W(DW), .ERR_W(EW)) bus ();

  demux1_l1 #(.DATA_W(DW), .ERR_W(EW)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_2f = ~clk_2f;

  // Present one serial word, let one edge take it, settle past the edge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    bus.valid_00 = v;
    bus.data_00  = d;
    @(posedge clk_2f);
    #1;
  endtask

  // Hold reset across an edge and release just after it, so the next edge is slot 0.
  task automatic apply_reset();
    reset = 1'b1;
    bus.valid_00 = 1'b0;
    bus.data_00  = '0;
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*DW+2:0] got;
    apply_reset();
    step(1'b1, 8'h5A);
    step(1'b1, 8'hC3);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== {8'h5A, 8'hC3, 3'b111}) begin
      n_fail++; $display("FAIL reset_pre_pair got=%h exp=%h", got, {8'h5A, 8'hC3, 3'b111});
    end
    #2;
    reset = 1'b1;
    #1;
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== '0 || bus.err_cnt !== '0) begin
      n_fail++; $display("FAIL reset_async got=%h err=%0d exp=0", got, bus.err_cnt);
    end
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
    step(1'b1, 8'h11);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_slot0 got=%h exp=0", got);
    end
    step(1'b1, 8'h22);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== {8'h11, 8'h22, 3'b111} || bus.err_cnt !== '0) begin
      n_fail++; $display("FAIL reset_first_pair got=%h err=%0d exp=%h err=0", got, bus.err_cnt, {8'h11, 8'h22, 3'b111});
    end
    step(1'b0, 8'h00);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== {8'h11, 8'h22, 3'b110}) begin
      n_fail++; $display("FAIL reset_stb_single got=%h exp=%h", got, {8'h11, 8'h22, 3'b110});
    end
  endtask

  task automatic test_stream();
    logic [2*DW+2:0] got;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      a = 8'hA0 + DW'(p);
      b = 8'hB0 + DW'(p);
      step(1'b1, a);
      n_checks++;
      if (bus.pair_stb !== 1'b0) begin
        n_fail++; $display("FAIL stream_gap%0d stb=%b exp=0", p, bus.pair_stb);
      end
      step(1'b1, b);
      got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
      n_checks++;
      if (got !== {a, b, 3'b111} || bus.err_cnt !== '0) begin
        n_fail++; $display("FAIL stream_pair%0d got=%h err=%0d exp=%h err=0", p, got, bus.err_cnt, {a, b, 3'b111});
      end
    end
  endtask

  task automatic test_invalid_hold();
    logic [2*DW+2:0] got;
    apply_reset();
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b0, 8'hFF);
    step(1'b0, 8'hFF);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== {8'h33, 8'h44, 3'b001} || bus.err_cnt !== '0) begin
      n_fail++; $display("FAIL invalid_hold got=%h err=%0d exp=%h err=0", got, bus.err_cnt, {8'h33, 8'h44, 3'b001});
    end
  endtask

  task automatic test_saturation();
    logic [2*DW+2:0] got;
    logic [DW-1:0]   a;
    int              exp_err;
    apply_reset();
    for (int k = 1; k <= 300; k++) begin
      a = DW'(k);
      step(1'b1, a);
      step(1'b0, 8'hEE);
      exp_err = (k > 255) ? 255 : k;
      got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
      n_checks++;
      if (got !== {a, 8'h00, 3'b101} || bus.err_cnt !== EW'(exp_err)) begin
        n_fail++; $display("FAIL sat_pair%0d got=%h err=%0d exp=%h err=%0d", k, got, bus.err_cnt, {a, 8'h00, 3'b101}, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_pair();
    logic [2*DW+2:0] got;
    apply_reset();
    step(1'b1, 8'h55);
    apply_reset();
    step(1'b1, 8'h66);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL midpair_slot0 got=%h exp=0", got);
    end
    step(1'b1, 8'h77);
    got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
    n_checks++;
    if (got !== {8'h66, 8'h77, 3'b111} || bus.err_cnt !== '0) begin
      n_fail++; $display("FAIL midpair_pair got=%h err=%0d exp=%h err=0", got, bus.err_cnt, {8'h66, 8'h77, 3'b111});
    end
  endtask

  // Tx interleaver model feeds random lane pairs; the reference tracks the last valid word per lane.
  task automatic test_loopback();
    logic [2*DW+2:0] got;
    logic [2*DW+2:0] exp;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;
    logic            v0;
    logic            v1;
    logic [DW-1:0]   last0;
    logic [DW-1:0]   last1;
    int              exp_err;
    apply_reset();
    last0   = '0;
    last1   = '0;
    exp_err = 0;
    for (int p = 0; p < 1000; p++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      step(v0, d0);
      n_checks++;
      if (bus.pair_stb !== 1'b0) begin
        n_fail++; $display("FAIL loop_gap%0d stb=%b exp=0", p, bus.pair_stb);
      end
      step(v1, d1);
      if (v0) last0 = d0;
      if (v1) last1 = d1;
      if ((v0 != v1) && exp_err < 255) exp_err++;
      exp = {last0, last1, v0, v1, 1'b1};
      got = {bus.data_0, bus.data_1, bus.valid_0, bus.valid_1, bus.pair_stb};
      n_checks++;
      if (got !== exp || bus.err_cnt !== EW'(exp_err)) begin
        n_fail++; $display("FAIL loop_pair%0d got=%h err=%0d exp=%h err=%0d", p, got, bus.err_cnt, exp, exp_err);
      end
    end
  endtask

  initial begin
    bus.valid_00 = 1'b0;
    bus.data_00  = '0;
    test_reset();
    test_stream();
    test_invalid_hold();
    test_saturation();
    test_reset_mid_pair();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
